// File: rtl/cfg_region_lookup.sv
// Sequential PMA region classifier: scans the execute, cached or non-idempotent
// base/length rule set one rule per cycle and reports the first matching rule.

package config_pkg;
  localparam int unsigned MaxRules = 16;

  typedef struct packed {
    int unsigned                 NrExecuteRegionRules;
    logic [MaxRules*64-1:0]      ExecuteRegionAddrBase;
    logic [MaxRules*64-1:0]      ExecuteRegionLength;
    int unsigned                 NrCachedRegionRules;
    logic [MaxRules*64-1:0]      CachedRegionAddrBase;
    logic [MaxRules*64-1:0]      CachedRegionLength;
    int unsigned                 NrNonIdempotentRules;
    logic [MaxRules*64-1:0]      NonIdempotentAddrBase;
    logic [MaxRules*64-1:0]      NonIdempotentLength;
  } cva6_cfg_t;
endpackage

package cva6_config_pkg;
  // Rule 0 debug module, rule 1 boot ROM, rule 2 DRAM.
  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {832'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  {960'h0, 64'h8000_0000},
    CachedRegionLength:    {960'h0, 64'h4000_0000},
    NrNonIdempotentRules:  2,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0
  };
endpackage

module cfg_region_lookup
  import config_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic [1:0]  req_type_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_hit_o,
  output logic [3:0]  resp_idx_o,
  output logic [1:0]  resp_type_o
);

  if (CVA6Cfg.NrExecuteRegionRules > MaxRules ||
      CVA6Cfg.NrCachedRegionRules  > MaxRules ||
      CVA6Cfg.NrNonIdempotentRules > MaxRules) begin : g_bad_cfg
    $error("cfg_region_lookup: region rule count exceeds 16");
  end

  // state | meaning
  // IDLE  | ready for a request
  // SCAN  | evaluating rule idx_q of the captured set, one rule per cycle
  // RESP  | response held until resp_ready_i
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  idx_q, idx_d;
  logic        hit_q, hit_d;
  logic [3:0]  ridx_q, ridx_d;

  logic [63:0] rule_base, rule_len;
  logic [64:0] rule_end;
  logic        rule_match;
  logic [4:0]  n_cur;

  function automatic logic [4:0] rule_cnt(input logic [1:0] t);
    case (t)
      2'b00:   return CVA6Cfg.NrExecuteRegionRules[4:0];
      2'b01:   return CVA6Cfg.NrCachedRegionRules[4:0];
      2'b10:   return CVA6Cfg.NrNonIdempotentRules[4:0];
      default: return 5'd0;
    endcase
  endfunction

  always_comb begin
    rule_base = '0;
    rule_len  = '0;
    case (type_q)
      2'b00: begin
        rule_base = CVA6Cfg.ExecuteRegionAddrBase[{idx_q, 6'b0} +: 64];
        rule_len  = CVA6Cfg.ExecuteRegionLength[{idx_q, 6'b0} +: 64];
      end
      2'b01: begin
        rule_base = CVA6Cfg.CachedRegionAddrBase[{idx_q, 6'b0} +: 64];
        rule_len  = CVA6Cfg.CachedRegionLength[{idx_q, 6'b0} +: 64];
      end
      2'b10: begin
        rule_base = CVA6Cfg.NonIdempotentAddrBase[{idx_q, 6'b0} +: 64];
        rule_len  = CVA6Cfg.NonIdempotentLength[{idx_q, 6'b0} +: 64];
      end
      default: ;
    endcase
    // 65-bit end so a region reaching 2^64 does not wrap to zero.
    rule_end   = {1'b0, rule_base} + {1'b0, rule_len};
    rule_match = (rule_len != 64'd0) && (addr_q >= rule_base) &&
                 ({1'b0, addr_q} < rule_end);
    n_cur      = rule_cnt(type_q);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    type_d       = type_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    ridx_d       = ridx_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          type_d  = req_type_i;
          idx_d   = 4'd0;
          hit_d   = 1'b0;
          ridx_d  = 4'd0;
          state_d = (rule_cnt(req_type_i) == 5'd0) ? RESP : SCAN;
        end
      end
      SCAN: begin
        if (rule_match) begin
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          state_d = RESP;
        end else if ({1'b0, idx_q} == n_cur - 5'd1) begin
          hit_d   = 1'b0;
          ridx_d  = 4'd0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
    end
  end

  assign resp_hit_o  = hit_q;
  assign resp_idx_o  = ridx_q;
  assign resp_type_o = type_q;

endmodule

// File: tb/tb_cfg_region_lookup.sv
// Directed bench for cfg_region_lookup: default tables on one instance, an
// overlapping / top-of-address-space table on a second instance.

module tb_cfg_region_lookup;

  localparam config_pkg::cva6_cfg_t Cfg2 = '{
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {832'h0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h1000},
    ExecuteRegionLength:   {832'h0, 64'h1_0000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   0,
    CachedRegionAddrBase:  '0,
    CachedRegionLength:    '0,
    NrNonIdempotentRules:  0,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0
  };

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_type = '0;
  logic        resp_ready = 1'b0;

  logic        rdy1, val1, hit1, rdy2, val2, hit2;
  logic [3:0]  idx1, idx2;
  logic [1:0]  typ1, typ2;

  logic        req_ready, resp_valid, resp_hit;
  logic [3:0]  resp_idx;
  logic [1:0]  resp_type;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  cfg_region_lookup u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid & ~sel), .req_ready_o(rdy1),
    .req_addr_i(req_addr), .req_type_i(req_type),
    .resp_valid_o(val1), .resp_ready_i(resp_ready & ~sel),
    .resp_hit_o(hit1), .resp_idx_o(idx1), .resp_type_o(typ1)
  );

  cfg_region_lookup #(.CVA6Cfg(Cfg2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid & sel), .req_ready_o(rdy2),
    .req_addr_i(req_addr), .req_type_i(req_type),
    .resp_valid_o(val2), .resp_ready_i(resp_ready & sel),
    .resp_hit_o(hit2), .resp_idx_o(idx2), .resp_type_o(typ2)
  );

  assign req_ready  = sel ? rdy2 : rdy1;
  assign resp_valid = sel ? val2 : val1;
  assign resp_hit   = sel ? hit2 : hit1;
  assign resp_idx   = sel ? idx2 : idx1;
  assign resp_type  = sel ? typ2 : typ1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called one step after the acceptance edge, i.e. in cycle 1.
  task automatic wait_resp(input string tag, input logic exp_hit, input logic [3:0] exp_idx,
                           input logic [1:0] exp_type, input int exp_lat);
    int lat;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " valid"}, resp_valid, 1'b1);
    check({tag, " hit"}, resp_hit, exp_hit);
    check({tag, " idx"}, resp_idx, exp_idx);
    check({tag, " type"}, resp_type, exp_type);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, " ready after resp"}, req_ready, 1'b1);
    check({tag, " valid after resp"}, resp_valid, 1'b0);
  endtask

  task automatic run_req(input string tag, input logic [63:0] addr, input logic [1:0] typ,
                         input logic exp_hit, input logic [3:0] exp_idx, input int exp_lat);
    req_addr  = addr;
    req_type  = typ;
    req_valid = 1'b1;
    check({tag, " ready before"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_type  = ~typ;
    wait_resp(tag, exp_hit, exp_idx, typ, exp_lat);
  endtask

  // Default-table reference: first matching rule, hit on k -> k+2, miss -> N+1.
  task automatic ref_lookup(input logic [63:0] a, input logic [1:0] t,
                            output logic hit, output logic [3:0] idx, output int lat);
    logic [63:0] b[3];
    logic [63:0] l[3];
    int n;
    n = 0;
    b = '{64'h0, 64'h0, 64'h0};
    l = '{64'h0, 64'h0, 64'h0};
    case (t)
      2'b00: begin
        n = 3;
        b = '{64'h0, 64'h1_0000, 64'h8000_0000};
        l = '{64'h1000, 64'h1_0000, 64'h4000_0000};
      end
      2'b01: begin
        n = 1;
        b[0] = 64'h8000_0000;
        l[0] = 64'h4000_0000;
      end
      2'b10: n = 2;
      default: n = 0;
    endcase
    hit = 1'b0;
    idx = 4'd0;
    lat = n + 1;
    for (int i = 0; i < n; i++) begin
      if (!hit && l[i] != 0 && a >= b[i] && {1'b0, a} < ({1'b0, b[i]} + {1'b0, l[i]})) begin
        hit = 1'b1;
        idx = 4'(i);
        lat = i + 2;
      end
    end
  endtask

  initial begin
    logic [63:0] cand[8];
    logic        r_hit;
    logic [3:0]  r_idx;
    int          r_lat;
    logic [63:0] a;
    logic [1:0]  t;
    bit          seen;

    rst_i = 1'b1;
    step();
    step();
    check("reset valid", resp_valid, 1'b0);
    check("reset hit", resp_hit, 1'b0);
    check("reset idx", resp_idx, 4'd0);
    check("reset type", resp_type, 2'd0);
    rst_i = 1'b0;
    step();
    check("ready after reset", req_ready, 1'b1);

    run_req("exec dram",       64'h8000_1000, 2'b00, 1'b1, 4'd2, 4);
    run_req("exec debug top",  64'h0000_0FFF, 2'b00, 1'b1, 4'd0, 2);
    run_req("exec dram end",   64'hC000_0000, 2'b00, 1'b0, 4'd0, 4);
    run_req("exec bootrom",    64'h0001_0000, 2'b00, 1'b1, 4'd1, 3);
    run_req("exec debug end",  64'h0000_1000, 2'b00, 1'b0, 4'd0, 4);
    run_req("nonidem zerolen", 64'h0000_1234, 2'b10, 1'b0, 4'd0, 3);
    run_req("reserved type",   64'h8000_0000, 2'b11, 1'b0, 4'd0, 1);
    run_req("cached below",    64'h7FFF_FFFF, 2'b01, 1'b0, 4'd0, 2);

    // Back-pressure: response held through cycles 2..7, second request waits.
    req_addr  = 64'h8000_0000;
    req_type  = 2'b01;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("bp cycle1 valid", resp_valid, 1'b0);
    step();
    req_addr  = 64'h0000_0FFF;
    req_type  = 2'b00;
    req_valid = 1'b1;
    for (int c = 2; c <= 7; c++) begin
      check($sformatf("bp c%0d valid", c), resp_valid, 1'b1);
      check($sformatf("bp c%0d hit", c), resp_hit, 1'b1);
      check($sformatf("bp c%0d idx", c), resp_idx, 4'd0);
      check($sformatf("bp c%0d type", c), resp_type, 2'b01);
      check($sformatf("bp c%0d req_ready", c), req_ready, 1'b0);
      if (c == 7) resp_ready = 1'b1;
      step();
    end
    resp_ready = 1'b0;
    check("bp c8 req_ready", req_ready, 1'b1);
    check("bp c8 valid", resp_valid, 1'b0);
    step();
    req_valid = 1'b0;
    wait_resp("bp second", 1'b1, 4'd0, 2'b00, 2);

    // Reset during cycle 2 of an execute scan aborts silently.
    req_addr  = 64'h8000_1000;
    req_type  = 2'b00;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("abort ready", req_ready, 1'b1);
    check("abort valid", resp_valid, 1'b0);
    check("abort hit", resp_hit, 1'b0);
    check("abort idx", resp_idx, 4'd0);
    check("abort type", resp_type, 2'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) seen = 1'b1;
      step();
    end
    check("abort no response", seen, 1'b0);

    cand = '{64'h0, 64'h1000, 64'h1_0000, 64'h2_0000,
             64'h8000_0000, 64'hC000_0000, 64'h8765_4321, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 24; i++) begin
      a = cand[$urandom_range(0, 7)] + 64'($urandom_range(0, 2)) - 64'd1;
      t = 2'($urandom_range(0, 3));
      ref_lookup(a, t, r_hit, r_idx, r_lat);
      run_req($sformatf("rand%0d a=%0h t=%0d", i, a, t), a, t, r_hit, r_idx, r_lat);
    end

    sel = 1'b1;
    step();
    run_req("cfg2 overlap low wins", 64'h0000_1800, 2'b00, 1'b1, 4'd0, 2);
    run_req("cfg2 rule1",            64'h0000_0800, 2'b00, 1'b1, 4'd1, 3);
    run_req("cfg2 top of space",     64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 4'd2, 4);
    run_req("cfg2 top base",         64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'd2, 4);
    run_req("cfg2 gap",              64'hFFFF_FFFE_FFFF_FFFF, 2'b00, 1'b0, 4'd0, 4);
    run_req("cfg2 cached none",      64'h0000_1800, 2'b01, 1'b0, 4'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_region_lookup.md
# cfg_region_lookup

Sequential reader of the physical-memory-attribute region tables carried in `config_pkg::cva6_cfg_t`. These tables are the execute, cached and non-idempotent base/length rule sets. A requester submits an address and a query type. The block scans the selected rule set one rule per cycle and returns hit/miss plus the index of the first matching rule. It sits beside the PMA/fetch/LSU logic as a shared, low-area alternative to fully parallel comparators, for slow-path users such as debug, PTW attribute checks and error reporting.

## Interface
- `CVA6Cfg`, `cva6_config_pkg::cva6_cfg`: source of `NrExecuteRegionRules`, `ExecuteRegionAddrBase/Length`, `NrCachedRegionRules`, `CachedRegionAddrBase/Length`, `NrNonIdempotentRules`, `NonIdempotentAddrBase/Length`. Rule i occupies bits [64*i+63:64*i].
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when valid and ready are both high.
- `req_addr_i` in 64: physical address to classify.
- `req_type_i` in 2: 00 execute, 01 cached, 10 non-idempotent, 11 reserved.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response consumed when valid and ready are both high.
- `resp_hit_o` out 1: address lies inside a rule of the selected set.
- `resp_idx_o` out 4: index of first matching rule; 0 on miss.
- `resp_type_o` out 2: echo of the captured `req_type_i`.

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE: `req_ready_o`=1. On handshake:
  - capture addr and type; clear idx counter.
  - Select rule count N from type; reserved type gives N=0.
  - If N=0, go to RESP with hit=0. Otherwise go to SCAN.
- SCAN: `req_ready_o`=0. Evaluate rule `idx` each cycle.
  - Match rule: length != 0 and base <= addr < base+length.
  - Compute base+length at 65 bits so a region ending at 2^64 does not wrap.
  - On match: hit=1, latch idx, go to RESP.
  - On no match and idx==N-1: hit=0, idx output 0, go to RESP.
  - Otherwise: idx+1.
  - Lower index wins on overlapping rules.
- RESP: `resp_valid_o`=1. `resp_hit_o`, `resp_idx_o` and `resp_type_o` are held stable until `resp_ready_i`. On handshake, go to IDLE.
- No new request is accepted while in SCAN or RESP; there is one outstanding request at most.
- `req_addr_i` and `req_type_i` may change after acceptance without effect.
- Reset: state goes to IDLE. `req_ready_o`=1 after the reset cycle. `resp_valid_o`=0, `resp_hit_o`=0, `resp_idx_o`=0, `resp_type_o`=0.
- Reset in SCAN or RESP aborts the request silently, with no response.
- Rule counts above 16 are a parameter error and fire an elaboration-time `$error`.

## Timing
- Acceptance edge = cycle 0.
- Hit on rule k: rule k is evaluated in cycle k+1; `resp_valid_o` is high from cycle k+2.
- Miss with N rules: `resp_valid_o` is high from cycle N+1.
- N=0 (including reserved type): `resp_valid_o` is high in cycle 1.
- The response handshake at cycle t puts `req_ready_o`=1 at cycle t+1. There is no back-to-back acceptance in the response cycle.
- Comparator path: one 64-bit rule mux, a 65-bit add and two compares per cycle, all registered at the end of SCAN.

## Test plan
- Execute query, addr 0x8000_1000, default config (rule0 debug 0x0/0x1000, rule1 boot ROM 0x1_0000/0x1_0000, rule2 DRAM 0x8000_0000/0x4000_0000) -> hit=1, idx=2, type=00, `resp_valid_o` rises in cycle 4.
- Execute query, addr 0x0000_0FFF -> hit=1, idx=0 in cycle 2. Execute query, addr 0xC000_0000 (exact DRAM end) -> hit=0, idx=0 in cycle 4.
- Non-idempotent query, any addr (both rules have length 0) -> hit=0 in cycle 3. Reserved type 11 -> hit=0, type=11 in cycle 1.
- Cached query, addr 0x8000_0000 with `resp_ready_i` held low for 5 cycles:
  - outputs stay hit=1, idx=0, valid=1 and `req_ready_o`=0 throughout;
  - handshake on cycle 7 -> `req_ready_o`=1 on cycle 8;
  - a second `req_valid_i` asserted during RESP is not accepted until cycle 8.
- `rst_i` pulsed in cycle 2 of an execute scan -> cycle 3 is IDLE with all outputs at reset values; `resp_valid_o` never rises for the aborted request.
- Randomised addr/type sequence against a parallel reference classifier -> hit/idx match, and latency equals the formula above for every request.
